// File: rtl/usr_ctrl_pkg.sv
// rtl/usr_ctrl_pkg.sv - shared encodings for the universal shift register sequencer
// Purpose: register select codes, command opcodes and FSM state codes used by
//   usr_ctrl, usr_shift_cnt and the benches.
// Macro: USR_CTRL_ROT_EN enables opcode 11 as rotate-right.
package usr_ctrl_pkg;

  // usr_select encodings understood by shift_reg
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // cmd_op encodings
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  // FSM state codes
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Opcodes that run the SHIFT state. Without rotate support op 11 behaves
  // like a zero-count command and goes straight to DONE.
  function automatic logic op_is_shift(input logic [1:0] op);
`ifdef USR_CTRL_ROT_EN
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROTR);
`else
    return (op == OP_SHR) || (op == OP_SHL);
`endif
  endfunction

endpackage

// File: rtl/usr_ctrl_shift_cnt.sv
// rtl/usr_ctrl_shift_cnt.sv - loadable down-counter tracking remaining shift cycles
// Purpose: holds the number of shift cycles still to run for the current command.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       load load_val (takes priority over dec)
//   load_val   CNT_W-bit count
//   dec        decrement by one
//   last       count equals 1, i.e. the current shift cycle is the final one
module usr_shift_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);
  import usr_ctrl_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/usr_ctrl.sv
// rtl/usr_ctrl.sv - command sequencer for the WIDTH-bit universal shift register
// Purpose: accepts LOAD / SHR / SHL (and ROTR when USR_CTRL_ROT_EN is defined)
//   commands over cmd_valid/cmd_ready, drives shift_reg cycle by cycle, streams
//   shifted-out bits on bit_out/bit_valid and pulses done with a result snapshot.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op/cmd_cnt/cmd_data/cmd_fill  command fields, latched on handshake
//   usr_select/usr_p_din/usr_s_left_din/usr_s_right_din  register controls
//   usr_p_dout/usr_s_left_dout/usr_s_right_dout          register outputs
//   bit_out/bit_valid             bit leaving the register in each SHIFT cycle
//   busy/done/result              status, completion pulse, parallel snapshot
// Macro: USR_CTRL_ROT_EN enables op 11 as rotate right.
module usr_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_p_din,
  output logic             usr_s_left_din,
  output logic             usr_s_right_din,
  input  logic [WIDTH-1:0] usr_p_dout,
  input  logic             usr_s_left_dout,
  input  logic             usr_s_right_dout,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  import usr_ctrl_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cnt_load, cnt_dec, cnt_last;

  usr_shift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cmd_cnt),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    fill_d   = fill_q;
    result_d = result_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d     = cmd_op;
          data_d   = cmd_data;
          fill_d   = cmd_fill;
          cnt_load = 1'b1;
          if (cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (op_is_shift(cmd_op) && (cmd_cnt != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_SHIFT: begin
        // The counter still holds N in the first shift cycle, so reaching 1
        // marks the Nth cycle.
        if (cnt_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        result_d = usr_p_dout;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      fill_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      fill_q   <= fill_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    usr_select = SEL_HOLD;
    if (state_q == ST_LOAD) begin
      usr_select = SEL_LOAD;
    end else if (state_q == ST_SHIFT) begin
      usr_select = (op_q == OP_SHL) ? SEL_SHL : SEL_SHR;
    end
  end

  assign usr_p_din      = (state_q == ST_LOAD) ? data_q : '0;
  assign usr_s_left_din = fill_q;

`ifdef USR_CTRL_ROT_EN
  // Rotate: feed the outgoing LSB straight back into the MSB.
  assign usr_s_right_din = (op_q == OP_ROTR) ? usr_s_right_dout : fill_q;
`else
  assign usr_s_right_din = fill_q;
`endif

  assign bit_valid = (state_q == ST_SHIFT);
  assign bit_out   = bit_valid && ((op_q == OP_SHL) ? usr_s_left_dout : usr_s_right_dout);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  // Show the live register value during DONE so result is valid with the pulse.
  assign result    = done ? usr_p_dout : result_q;

endmodule

// File: tb/tb_usr_ctrl.sv
// tb/tb_usr_ctrl.sv - self-checking bench for usr_ctrl driving a shift register model
module tb_usr_ctrl;
  import usr_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_fill;
  logic [1:0] usr_select;
  logic [3:0] usr_p_din, usr_p_dout, result;
  logic       usr_s_left_din, usr_s_right_din, usr_s_left_dout, usr_s_right_dout;
  logic       bit_out, bit_valid, busy, done;
  logic [3:0] sr_q = 4'b0000;
  logic       mon_en = 1'b0;

  int tests = 0;
  int fails = 0;

  logic       bit_q[$];
  logic [3:0] res_q[$];

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic [3:0] data;
    logic       fill;
    logic [3:0] exp_res;
    logic [7:0] exp_bits;
    int         nbits;
    int         exp_done;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  usr_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_cnt          (cmd_cnt),
    .cmd_data         (cmd_data),
    .cmd_fill         (cmd_fill),
    .usr_select       (usr_select),
    .usr_p_din        (usr_p_din),
    .usr_s_left_din   (usr_s_left_din),
    .usr_s_right_din  (usr_s_right_din),
    .usr_p_dout       (usr_p_dout),
    .usr_s_left_dout  (usr_s_left_dout),
    .usr_s_right_dout (usr_s_right_dout),
    .bit_out          (bit_out),
    .bit_valid        (bit_valid),
    .busy             (busy),
    .done             (done),
    .result           (result)
  );

  // Behavioural universal shift register; not reset, contents survive aborts.
  always_ff @(posedge clk) begin
    case (usr_select)
      SEL_SHR:  sr_q <= {usr_s_right_din, sr_q[3:1]};
      SEL_SHL:  sr_q <= {sr_q[2:0], usr_s_left_din};
      SEL_LOAD: sr_q <= usr_p_din;
      default:  sr_q <= sr_q;
    endcase
  end
  assign usr_p_dout       = sr_q;
  assign usr_s_left_dout  = sr_q[3];
  assign usr_s_right_dout = sr_q[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] sel_for(input logic [1:0] op);
    if (op == 2'b00) return 2'b11;
    if (op == 2'b10) return 2'b10;
    return 2'b01;
  endfunction

  // Scoreboard: pop expected bits/results as the DUT produces them.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bit_valid) begin
        if (bit_q.size() == 0) begin
          check("unexpected bit_valid", 32'(bit_valid), 32'd0);
        end else begin
          check("bit_out", 32'(bit_out), 32'(bit_q.pop_front()));
        end
      end else if (bit_out !== 1'b0) begin
        check("bit_out idle", 32'(bit_out), 32'd0);
      end
      if (done) begin
        if (res_q.size() == 0) begin
          check("unexpected done", 32'(done), 32'd0);
        end else begin
          check("result", 32'(result), 32'(res_q.pop_front()));
        end
      end
    end
  end

  task automatic run_cmd(input vec_t v, input string tag);
    bit seen;
    logic [1:0] exp_sel;
    logic [3:0] exp_din;
    @(negedge clk);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_cnt   = v.cnt;
    cmd_data  = v.data;
    cmd_fill  = v.fill;
    res_q.push_back(v.exp_res);
    for (int i = 0; i < v.nbits; i++) bit_q.push_back(v.exp_bits[i]);
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      // Scramble the command bus and keep cmd_valid high: must be ignored.
      cmd_op   = 2'($urandom_range(3, 0));
      cmd_cnt  = 3'($urandom_range(7, 0));
      cmd_data = 4'($urandom_range(15, 0));
      cmd_fill = 1'($urandom_range(1, 0));
      exp_sel  = (k < v.exp_done) ? sel_for(v.op) : SEL_HOLD;
      exp_din  = (k < v.exp_done && v.op == OP_LOAD) ? v.data : 4'b0000;
      check({tag, " usr_select"}, 32'(usr_select), 32'(exp_sel));
      check({tag, " usr_p_din"}, 32'(usr_p_din), 32'(exp_din));
      check({tag, " busy"}, 32'(busy), 32'd1);
      if (done) begin
        seen = 1;
        check({tag, " done cycle"}, k, v.exp_done);
        cmd_valid = 1'b0;
      end
    end
    if (!seen) check({tag, " done timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    vec_t ab;
    vecs[0]  = '{OP_LOAD, 3'd0, 4'b1101, 1'b0, 4'b1101, 8'h00, 0, 2};
    vecs[1]  = '{OP_SHR,  3'd2, 4'b0000, 1'b1, 4'b1111, 8'b01, 2, 3};
    vecs[2]  = '{OP_LOAD, 3'd5, 4'b1101, 1'b1, 4'b1101, 8'h00, 0, 2};
    vecs[3]  = '{OP_SHL,  3'd3, 4'b0000, 1'b0, 4'b1000, 8'b011, 3, 4};
    vecs[4]  = '{OP_SHR,  3'd0, 4'b1111, 1'b1, 4'b1000, 8'h00, 0, 1};
    vecs[5]  = '{OP_SHL,  3'd1, 4'b0000, 1'b1, 4'b0001, 8'b1, 1, 2};
    vecs[6]  = '{OP_LOAD, 3'd0, 4'b1101, 1'b0, 4'b1101, 8'h00, 0, 2};
`ifdef USR_CTRL_ROT_EN
    vecs[7]  = '{OP_ROTR, 3'd4, 4'b0000, 1'b0, 4'b1101, 8'b1101, 4, 5};
`else
    vecs[7]  = '{OP_ROTR, 3'd4, 4'b0000, 1'b0, 4'b1101, 8'h00, 0, 1};
`endif
    vecs[8]  = '{OP_SHR,  3'd7, 4'b0000, 1'b0, 4'b0000, 8'b0001101, 7, 8};
    vecs[9]  = '{OP_LOAD, 3'd0, 4'b0110, 1'b0, 4'b0110, 8'h00, 0, 2};
    vecs[10] = '{OP_SHL,  3'd2, 4'b0000, 1'b1, 4'b1011, 8'b10, 2, 3};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 3'd0;
    cmd_data = 4'd0; cmd_fill = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst usr_select", 32'(usr_select), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 11; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Abort: LOAD 1101 then reset after the first of three right shifts.
    run_cmd(vecs[0], "abort preload");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_cnt = 3'd3; cmd_fill = 1'b0;
    bit_q.push_back(1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort shifting", 32'(usr_select), 32'(SEL_SHR));
    rst = 1'b1;
    @(negedge clk);
    check("abort usr_select", 32'(usr_select), 32'd0);
    check("abort bit_valid", 32'(bit_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort fill", 32'({usr_s_left_din, usr_s_right_din}), 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort no done", 32'(done), 32'd0);
    end
    // Register kept 0110 (1101 shifted once with fill 0).
    ab = '{OP_SHR, 3'd1, 4'b0000, 1'b1, 4'b1011, 8'b0, 1, 2};
    run_cmd(ab, "after abort");

    @(negedge clk);
    check("bit queue drained", bit_q.size(), 0);
    check("result queue drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
